// File: rtl/dma_param_fifo.sv
// Parametrised show-ahead circular FIFO for the AHB DMA datapath.
// Tracks occupancy, decodes programmable almost-full/almost-empty thresholds,
// supports synchronous flush and keeps sticky overflow/underflow error flags.
module dma_param_fifo #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12,
    parameter int unsigned AE_THRESH = 4,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [LW-1:0]     level,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              wr_acc, rd_acc;

    // Status flags decoded straight from the registered level.
    always_comb begin
        full         = (level_q == LW'(DEPTH));
        empty        = (level_q == '0);
        almost_full  = (level_q >= LW'(AF_THRESH));
        almost_empty = (level_q <= LW'(AE_THRESH));
        level        = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
        rd_data      = empty ? '0 : mem_q[rd_ptr_q];
    end

    // Accept decisions use pre-edge flags; flush masks both requests and their errors.
    always_comb begin
        wr_acc      = wr_en & ~full & ~flush;
        rd_acc      = rd_en & ~empty & ~flush;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        // Clear first so a same-cycle new error wins over err_clr.
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && wr_en && full)  overflow_d  = 1'b1;
        if (!flush && rd_en && empty) underflow_d = 1'b1;
    end

    // Pointer, level and error-flag registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are never reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_dma_param_fifo.sv
// Directed self-checking bench: default 32x16 instance plus an 8x4 instance.
module tb_dma_param_fifo;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 32x16 instance, AF=12, AE=4
    logic        flush = 0, wr_en = 0, rd_en = 0, err_clr = 0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  level;

    dma_param_fifo #(.DATA_W(32), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    // 8x4 instance, AF=3, AE=1
    logic       b_flush = 0, b_wr_en = 0, b_rd_en = 0, b_err_clr = 0;
    logic [7:0] b_wr_data = '0;
    logic [7:0] b_rd_data;
    logic       b_full, b_empty, b_almost_full, b_almost_empty, b_overflow, b_underflow;
    logic [2:0] b_level;

    dma_param_fifo #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .full(b_full), .empty(b_empty),
        .almost_full(b_almost_full), .almost_empty(b_almost_empty), .level(b_level),
        .overflow(b_overflow), .underflow(b_underflow), .err_clr(b_err_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin n_fail++; $display("FAIL reset_flags: got %b expected 1100", {empty, almost_empty, full, almost_full}); end
        n_checks++; if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_errors: got %b expected 00", {overflow, underflow}); end
        n_checks++; if ({b_level, b_empty, b_full, b_rd_data} !== {3'd0, 1'b1, 1'b0, 8'h00}) begin n_fail++; $display("FAIL reset_small: got lvl=%0d e=%b f=%b d=%h expected 0 1 0 00", b_level, b_empty, b_full, b_rd_data); end
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = i;
            tick();
            n_checks++; if (level !== 5'(i)) begin n_fail++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, level, i); end
            n_checks++; if (almost_full !== (i >= 12)) begin n_fail++; $display("FAIL fill_af[%0d]: got %b expected %b", i, almost_full, (i >= 12)); end
            n_checks++; if (full !== (i == 16)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 16)); end
            n_checks++; if (almost_empty !== (i <= 4)) begin n_fail++; $display("FAIL fill_ae[%0d]: got %b expected %b", i, almost_empty, (i <= 4)); end
            n_checks++; if (rd_data !== 32'h1) begin n_fail++; $display("FAIL fill_head[%0d]: got %h expected 1", i, rd_data); end
        end
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1; wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (level !== 5'd16 || rd_data !== 32'h1) begin n_fail++; $display("FAIL ovf_state: got lvl=%0d head=%h expected 16 1", level, rd_data); end
        // full + wr + rd: read taken, write dropped
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hBEEF;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (level !== 5'd15 || full !== 1'b0) begin n_fail++; $display("FAIL full_wr_rd: got lvl=%0d full=%b expected 15 0", level, full); end
        for (int i = 2; i <= 16; i++) begin
            n_checks++; if (rd_data !== 32'(i)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, rd_data, i); end
            rd_en = 1'b1;
            tick();
        end
        rd_en = 1'b0;
        n_checks++; if (empty !== 1'b1 || rd_data !== 32'h0 || level !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got e=%b d=%h lvl=%0d expected 1 0 0", empty, rd_data, level); end
        n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL drain_underflow: got %b expected 0", underflow); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 32'h100 + i;
            tick();
        end
        n_checks++; if (level !== 5'd8) begin n_fail++; $display("FAIL b2b_prefill: got %0d expected 8", level); end
        for (int k = 0; k < 40; k++) begin
            n_checks++; if (rd_data !== 32'h100 + k) begin n_fail++; $display("FAIL b2b_head[%0d]: got %h expected %h", k, rd_data, 32'h100 + k); end
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h108 + k;
            tick();
            n_checks++; if (level !== 5'd8) begin n_fail++; $display("FAIL b2b_level[%0d]: got %0d expected 8", k, level); end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (rd_data !== 32'h128) begin n_fail++; $display("FAIL b2b_final_head: got %h expected 128", rd_data); end
    endtask

    task automatic test_underflow();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (level !== 5'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL uf_flush: got lvl=%0d ovf=%b expected 0 1", level, overflow); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_checks++; if (underflow !== 1'b1 || level !== 5'd0) begin n_fail++; $display("FAIL uf_set: got uf=%b lvl=%0d expected 1 0", underflow, level); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL uf_clear: got %b expected 00", {overflow, underflow}); end
        err_clr = 1'b1; rd_en = 1'b1;
        tick();
        err_clr = 1'b0; rd_en = 1'b0;
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_set_wins: got %b expected 1", underflow); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        // empty + wr + rd: write taken, read dropped
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h77;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (level !== 5'd1 || underflow !== 1'b1 || rd_data !== 32'h77) begin n_fail++; $display("FAIL empty_wr_rd: got lvl=%0d uf=%b d=%h expected 1 1 77", level, underflow, rd_data); end
        rd_en = 1'b1; err_clr = 1'b1;
        tick();
        rd_en = 1'b0; err_clr = 1'b0;
        n_checks++; if (level !== 5'd0 || underflow !== 1'b0) begin n_fail++; $display("FAIL uf_pop_clear: got lvl=%0d uf=%b expected 0 0", level, underflow); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 32'h200 + i;
            tick();
        end
        wr_en = 1'b0;
        n_checks++; if (level !== 5'd10) begin n_fail++; $display("FAIL flush_prefill: got %0d expected 10", level); end
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h999;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        n_checks++; if (level !== 5'd0 || empty !== 1'b1 || rd_data !== 32'h0) begin n_fail++; $display("FAIL flush_state: got lvl=%0d e=%b d=%h expected 0 1 0", level, empty, rd_data); end
        n_checks++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL flush_errors: got %b expected 00", {overflow, underflow}); end
        wr_en = 1'b1; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        n_checks++; if (rd_data !== 32'h55 || level !== 5'd1) begin n_fail++; $display("FAIL flush_next_write: got d=%h lvl=%0d expected 55 1", rd_data, level); end
    endtask

    task automatic test_async_reset();
        flush = 1'b1;
        tick();
        flush = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 32'h300 + i;
            tick();
        end
        n_checks++; if (level !== 5'd3 || underflow !== 1'b1) begin n_fail++; $display("FAIL arst_pre: got lvl=%0d uf=%b expected 3 1", level, underflow); end
        // wr_en still high; assert reset between edges
        #2 rst = 1'b1;
        #1;
        n_checks++; if (level !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin n_fail++; $display("FAIL arst_level: got lvl=%0d e=%b ae=%b expected 0 1 1", level, empty, almost_empty); end
        n_checks++; if ({full, almost_full, overflow, underflow} !== 4'b0000 || rd_data !== 32'h0) begin n_fail++; $display("FAIL arst_flags: got f/af/ov/uf=%b d=%h expected 0000 0", {full, almost_full, overflow, underflow}, rd_data); end
        wr_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_small();
        for (int i = 1; i <= 4; i++) begin
            b_wr_en = 1'b1; b_wr_data = 8'(i);
            tick();
            n_checks++; if (b_level !== 3'(i) || b_almost_full !== (i >= 3) || b_full !== (i == 4) || b_almost_empty !== (i <= 1)) begin n_fail++; $display("FAIL small_fill[%0d]: got lvl=%0d af=%b f=%b ae=%b", i, b_level, b_almost_full, b_full, b_almost_empty); end
        end
        b_wr_data = 8'hAD;
        tick();
        b_wr_en = 1'b0;
        n_checks++; if (b_overflow !== 1'b1 || b_level !== 3'd4) begin n_fail++; $display("FAIL small_ovf: got ov=%b lvl=%0d expected 1 4", b_overflow, b_level); end
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (b_rd_data !== 8'(i)) begin n_fail++; $display("FAIL small_drain[%0d]: got %h expected %h", i, b_rd_data, i); end
            b_rd_en = 1'b1;
            tick();
        end
        b_rd_en = 1'b0;
        n_checks++; if (b_empty !== 1'b1 || b_rd_data !== 8'h0) begin n_fail++; $display("FAIL small_empty: got e=%b d=%h expected 1 00", b_empty, b_rd_data); end
        for (int i = 0; i < 2; i++) begin
            b_wr_en = 1'b1; b_wr_data = 8'h40 + 8'(i);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            n_checks++; if (b_rd_data !== 8'h40 + 8'(k)) begin n_fail++; $display("FAIL small_b2b[%0d]: got %h expected %h", k, b_rd_data, 8'h40 + 8'(k)); end
            b_wr_en = 1'b1; b_rd_en = 1'b1; b_wr_data = 8'h42 + 8'(k);
            tick();
        end
        b_wr_en = 1'b0; b_rd_en = 1'b0;
        n_checks++; if (b_level !== 3'd2 || b_rd_data !== 8'h4A) begin n_fail++; $display("FAIL small_b2b_end: got lvl=%0d d=%h expected 2 4a", b_level, b_rd_data); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_overflow();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_async_reset();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
